// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants, field-placement helpers and the encode function
// used by the instruction-injection encoder.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned ENTRY_W   = 33;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // err sits above instr so the packed entry is {err, instr}.
  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  function automatic logic [31:0] fmt_r(input fields_t f);
    return {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
  endfunction

  function automatic logic [31:0] fmt_i(input fields_t f);
    return {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
  endfunction

  function automatic logic [31:0] fmt_s(input fields_t f);
    return {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
  endfunction

  function automatic logic [31:0] fmt_b(input fields_t f);
    return {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
            f.imm[4:1], f.imm[11], f.opcode};
  endfunction

  function automatic logic [31:0] fmt_j(input fields_t f);
    return {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
  endfunction

  function automatic logic [31:0] fmt_u(input fields_t f);
    return {f.imm[31:12], f.rd, f.opcode};
  endfunction

  // Unrepresentable immediates still produce the truncated word, flagged err.
  function automatic entry_t encode(input fields_t f);
    entry_t e;
    e.instr = NOP_INSTR;
    e.err   = 1'b0;
    case (f.opcode)
      OPC_OP: begin
        e.instr = fmt_r(f);
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        e.instr = fmt_i(f);
        e.err   = (f.imm[31:12] != '0);
      end
      OPC_STORE: begin
        e.instr = fmt_s(f);
        e.err   = (f.imm[31:12] != '0);
      end
      OPC_BRANCH: begin
        e.instr = fmt_b(f);
        e.err   = (f.imm[31:13] != '0) || f.imm[0];
      end
      OPC_JAL: begin
        e.instr = fmt_j(f);
        e.err   = (f.imm[31:21] != '0) || f.imm[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        e.instr = fmt_u(f);
        e.err   = (f.imm[11:0] != '0);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        e.instr = fmt_r(f);
      end
      default: begin
        e.instr = NOP_INSTR;
        e.err   = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo2.sv
// Two-entry synchronous FIFO with registered count; head reads as zero when empty.
module sync_fifo2
  import instr_encoder_pkg::*;
#(
  parameter int unsigned W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty masks stale contents at dout.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with valid/ready input, 2-entry output FIFO and
// a saturating count of entries flagged as unrepresentable or unknown.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Only a depth of 2 is implemented; FIFO_DEPTH exists for interface stability.
  localparam int unsigned DEPTH_UNUSED = FIFO_DEPTH;

  fields_t              fields;
  entry_t               enc_entry;
  entry_t               head_entry;
  logic [ENTRY_W-1:0]   head_raw;
  logic [1:0]           fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, imm: imm};

  always_comb begin
    enc_entry = encode(fields);
  end

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (enc_entry),
    .dout  (head_raw),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_entry = entry_t'(head_raw);
  assign instr      = head_entry.instr;
  assign err        = head_entry.err;

  always_comb begin
    err_count_d = err_count_q;
    if (push && enc_entry.err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder plus hand-written sequences
// for backpressure, counter saturation and reset with queued entries.
module tb_instr_encoder;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_passed = 0;
  int exp_cnt  = 0;

  instr_encoder #(
    .FIFO_DEPTH (2),
    .ERR_CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd_i,
                              input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm_i, input logic [31:0] ei,
                              input logic ee);
    vec_t v;
    v.op = op; v.rd = rd_i; v.rs1 = rs1_i; v.rs2 = rs2_i; v.f3 = f3; v.f7 = f7;
    v.imm = imm_i; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic bump_cnt();
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  initial begin
    vecs[0]  = mk(7'h13, 1, 2, 0, 0, 0,    32'h5,        32'h00510093, 0);
    vecs[1]  = mk(7'h63, 0, 1, 2, 0, 0,    32'h10,       32'h00208863, 0);
    vecs[2]  = mk(7'h63, 0, 1, 2, 0, 0,    32'h11,       32'h00208863, 1);
    vecs[3]  = mk(7'h6F, 1, 0, 0, 0, 0,    32'h800,      32'h001000EF, 0);
    vecs[4]  = mk(7'h37, 5, 0, 0, 0, 0,    32'h12345000, 32'h123452B7, 0);
    vecs[5]  = mk(7'h37, 5, 0, 0, 0, 0,    32'h12345001, 32'h123452B7, 1);
    vecs[6]  = mk(7'h33, 1, 2, 3, 0, 7'h20, 32'hDEADBEEF, 32'h403100B3, 0);
    vecs[7]  = mk(7'h23, 0, 1, 2, 2, 0,    32'h8,        32'h0020A423, 0);
    vecs[8]  = mk(7'h17, 3, 0, 0, 0, 0,    32'h1000,     32'h00001197, 0);
    vecs[9]  = mk(7'h0F, 0, 0, 0, 1, 0,    32'hFFFFFFFF, 32'h0000100F, 0);
    vecs[10] = mk(7'h03, 1, 2, 0, 2, 0,    32'h1000,     32'h00012083, 1);
    vecs[11] = mk(7'h63, 0, 0, 0, 0, 0,    32'h1FFE,     32'hFE000FE3, 0);
    vecs[12] = mk(7'h6F, 0, 0, 0, 0, 0,    32'h100000,   32'h8000006F, 0);
    vecs[13] = mk(7'h6F, 0, 0, 0, 0, 0,    32'h200000,   32'h0000006F, 1);
    vecs[14] = mk(7'h7F, 1, 2, 3, 0, 0,    32'h5,        32'h00000013, 1);
    vecs[15] = mk(7'h67, 1, 5, 0, 0, 0,    32'hFFF,      32'hFFF280E7, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_instr",     instr,          32'd0);
    check("reset_err",       32'(err),       32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);

    // Table: push one entry, check head one cycle later, then pop it.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_no_bypass", i), 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      if (vecs[i].exp_err) bump_cnt();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_instr", i),     instr,          vecs[i].exp_instr);
      check($sformatf("vec%0d_err", i),       32'(err),       32'(vecs[i].exp_err));
      check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(exp_cnt));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: A, B fill the FIFO, C is held at the source.
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1; tick();
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    drive(vecs[3]); tick();
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    drive(vecs[4]); tick(); tick();
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_head_a",     instr,         32'h00510093);
    out_ready = 1'b1; tick();
    check("bp_head_b",     instr,         32'h001000EF);
    check("bp_ready_pop",  32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head_c",     instr,         32'h123452B7);
    check("bp_count1_rdy", 32'(in_ready), 32'd1);
    check("bp_count1_vld", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Saturation: stream unknown-opcode errors through the FIFO.
    out_ready = 1'b1;
    drive(vecs[14]);
    in_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      bump_cnt();
    end
    check("sat_reached", 32'(err_count), 32'(CNT_MAX));
    tick();
    bump_cnt();
    check("sat_hold",  32'(err_count), 32'(CNT_MAX));
    check("sat_model", 32'(exp_cnt),   32'(CNT_MAX));
    in_valid = 1'b0;
    tick();

    // Reset with two entries queued.
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1;
    begin : fill
      int budget = 0;
      while (in_ready && budget < 10) begin
        tick();
        budget++;
      end
      check("fill_full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_instr",     instr,          32'd0);
    tick();
    check("rst_stays_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
